dsp_mac_sequencer: RTL and testbench

Control sequencer that drives the clock-enable, reset and accumulate-select pins of the DSP48A1 datapath's pipeline registers: A/B input stage, M (multiplier) stage, P (accumulator) stage. It accepts a multiply-accumulate command, streams operand beats through a valid/ready handshake, and schedules the per-stage enables so each beat is captured exactly once at every stage. It raises `res_valid` when the P register holds the final sum. It sits between the command/operand source and the datapath's register stages, and is the only producer of their CE/RST inputs.

---
 rtl/dsp_seq_pkg.sv | 27 ++
 rtl/dsp_valid_pipe.sv | 41 ++++
 rtl/dsp_mac_sequencer.sv | 106 ++++++++++
 tb/tb_dsp_mac_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 MAC control sequencer.
// PIPE_LAT counts cycles from the last operand beat to res_valid.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam logic ACC_LOAD = 1'b0;
  localparam logic ACC_ADD  = 1'b1;
  localparam int   PIPE_LAT = 3;

  // One in-flight beat: p_only marks the clear-only token that must skip the M stage.
  typedef struct packed {
    logic vld;
    logic tag;
    logic p_only;
  } pipe_ent_t;

  function automatic logic acc_sel_of(input pipe_ent_t e);
    return (e.vld && !e.tag) ? ACC_ADD : ACC_LOAD;
  endfunction

endpackage

// File: rtl/dsp_valid_pipe.sv
// Shift register carrying {valid, first-clear tag} alongside the datapath M/P stages.
// One cycle per stage, never stalls; synchronous clear drops every token in flight.
module dsp_valid_pipe
  import dsp_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_clr,
  input  pipe_ent_t i_ent,
  output logic      o_ce_m,
  output logic      o_ce_p,
  output logic      o_acc_sel,
  output logic      o_upper_empty
);

  localparam int DEPTH = PIPE_LAT - 1;

  pipe_ent_t r_stg [DEPTH];
  logic      w_upper_vld;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_stg[i] <= '0;
    end else begin
      r_stg[0] <= i_ent;
      for (int i = 1; i < DEPTH; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  // Only the last stage may still be occupied when the pipe empties on the next edge.
  always_comb begin
    w_upper_vld = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) w_upper_vld = w_upper_vld | r_stg[i].vld;
  end

  assign o_upper_empty = !w_upper_vld;
  assign o_ce_m        = r_stg[0].vld && !r_stg[0].p_only;
  assign o_ce_p        = r_stg[DEPTH-1].vld;
  assign o_acc_sel     = acc_sel_of(r_stg[DEPTH-1]);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives CE/RST/acc-select of the DSP48A1 A/B, M and P stages for one MAC command at a time.
// Beat at t -> ce_ab t, ce_m t+1, ce_p t+2, res_valid at last beat + 3; abort cancels and pulses rst_pipe.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [LEN_W-1:0] op_len,
  input  logic             op_clr,
  input  logic             abort,
  input  logic             smp_valid,
  output logic             smp_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic             acc_sel,
  output logic             rst_pipe,
  output logic             res_valid,
  output logic             busy
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [LEN_W-1:0] r_remain;
  logic             r_first_clr;
  logic             r_abort_q;
  logic             w_op_acc;
  logic             w_upper_empty;
  pipe_ent_t        w_ent;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_op_acc) w_state_nxt = (op_len != '0) ? ST_LOAD : ST_DRAIN;
        ST_LOAD:  if (ce_ab && r_remain == LEN_W'(1)) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_upper_empty) w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Abort suppresses both handshakes and the result pulse in the same cycle.
  always_comb begin
    op_ready  = 1'b0;
    smp_ready = 1'b0;
    res_valid = 1'b0;
    w_ent     = '0;
    case (r_state)
      ST_IDLE: op_ready  = !abort && !rst;
      ST_LOAD: smp_ready = !abort && !rst;
      ST_DONE: res_valid = !abort && !rst;
      default: ;
    endcase
    w_op_acc = op_valid && op_ready;
    ce_ab    = smp_valid && smp_ready;
    if (ce_ab)
      w_ent = '{vld: 1'b1, tag: r_first_clr, p_only: 1'b0};
    else if (w_op_acc && op_len == '0 && op_clr)
      w_ent = '{vld: 1'b1, tag: 1'b1, p_only: 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remain    <= '0;
      r_first_clr <= 1'b0;
      r_abort_q   <= 1'b0;
    end else begin
      r_abort_q <= abort;
      if (w_op_acc) begin
        r_remain    <= op_len;
        r_first_clr <= op_clr;
      end else if (ce_ab) begin
        if (r_remain != '0) r_remain <= r_remain - LEN_W'(1);
        r_first_clr <= 1'b0;
      end
    end
  end

  dsp_valid_pipe u_pipe (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (abort),
    .i_ent         (w_ent),
    .o_ce_m        (ce_m),
    .o_ce_p        (ce_p),
    .o_acc_sel     (acc_sel),
    .o_upper_empty (w_upper_empty)
  );

  assign rst_pipe = rst || r_abort_q;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed and randomized bench for dsp_mac_sequencer; expected CE/result traces are
// derived from each command's beat times rather than from the sequencer's states.
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 8;
  localparam int MAXC  = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  logic             op_ready;
  logic [LEN_W-1:0] op_len;
  logic             op_clr;
  logic             abort;
  logic             smp_valid;
  logic             smp_ready;
  logic             ce_ab;
  logic             ce_m;
  logic             ce_p;
  logic             acc_sel;
  logic             rst_pipe;
  logic             res_valid;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;
  bit pat_q[$];

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_len    (op_len),
    .op_clr    (op_clr),
    .abort     (abort),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .ce_ab     (ce_ab),
    .ce_m      (ce_m),
    .ce_p      (ce_p),
    .acc_sel   (acc_sel),
    .rst_pipe  (rst_pipe),
    .res_valid (res_valid),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, plays pat_q on smp_valid from the cycle after accept, checks every cycle.
  task automatic run_cmd(input string name, input int len, input bit clr);
    bit e_ab [MAXC], e_m [MAXC], e_p [MAXC], e_acc [MAXC], e_res [MAXC], e_busy [MAXC];
    bit o_ab [MAXC], o_m [MAXC], o_p [MAXC], o_acc [MAXC], o_res [MAXC], o_busy [MAXC];
    int L, nc, n, last, res_k;
    bit acc;
    L  = pat_q.size();
    nc = L + 6;
    for (int k = 0; k < MAXC; k++) begin
      e_ab[k] = 0; e_m[k] = 0; e_p[k] = 0; e_acc[k] = 0; e_res[k] = 0; e_busy[k] = 0;
    end
    n = 0; last = 0;
    for (int i = 0; i < L; i++) begin
      if (pat_q[i] && n < len) begin
        n++;
        e_ab[i+1]  = 1;
        e_m[i+2]   = 1;
        e_p[i+3]   = 1;
        e_acc[i+3] = !(n == 1 && clr);
        last       = i + 1;
      end
    end
    if (len == 0) begin
      res_k = clr ? 3 : 2;
      if (clr) begin e_p[2] = 1; e_acc[2] = 0; end
    end else begin
      res_k = last + 3;
    end
    e_res[res_k] = 1;
    for (int k = 1; k <= res_k; k++) e_busy[k] = 1;

    op_len = LEN_W'(len); op_clr = clr; op_valid = 1'b1; smp_valid = 1'b0;
    acc = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (op_ready) begin acc = 1; break; end
      next_cyc();
    end
    chk({name, "_accept"}, 32'(acc), 32'd1);
    if (!acc) begin
      op_valid = 1'b0;
      next_cyc();
      return;
    end
    for (int k = 0; k < nc; k++) begin
      if (k > 0) begin
        next_cyc();
        op_valid  = 1'b0;
        smp_valid = (k - 1 < L) ? pat_q[k-1] : 1'b0;
        @(negedge clk);
      end
      o_ab[k] = ce_ab; o_m[k] = ce_m; o_p[k] = ce_p;
      o_acc[k] = acc_sel; o_res[k] = res_valid; o_busy[k] = busy;
    end
    next_cyc();
    smp_valid = 1'b0;
    for (int k = 0; k < nc; k++) begin
      chk($sformatf("%s_ce_ab@%0d", name, k), 32'(o_ab[k]), 32'(e_ab[k]));
      chk($sformatf("%s_ce_m@%0d", name, k), 32'(o_m[k]), 32'(e_m[k]));
      chk($sformatf("%s_ce_p@%0d", name, k), 32'(o_p[k]), 32'(e_p[k]));
      chk($sformatf("%s_res@%0d", name, k), 32'(o_res[k]), 32'(e_res[k]));
      chk($sformatf("%s_busy@%0d", name, k), 32'(o_busy[k]), 32'(e_busy[k]));
      if (e_p[k]) chk($sformatf("%s_acc_sel@%0d", name, k), 32'(o_acc[k]), 32'(e_acc[k]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int acc_q[$];
    int res_q[$];
    int n_ce, n_res;

    rst = 1'b1; op_valid = 1'b0; op_len = '0; op_clr = 1'b0; abort = 1'b0; smp_valid = 1'b0;

    // Reset state
    next_cyc();
    @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 0);
    chk("rst_rst_pipe", 32'(rst_pipe), 1);
    chk("rst_smp_ready", 32'(smp_ready), 0);
    chk("rst_ce", 32'({ce_ab, ce_m, ce_p}), 0);
    chk("rst_acc_sel", 32'(acc_sel), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_op_ready", 32'(op_ready), 1);
    chk("post_rst_rst_pipe", 32'(rst_pipe), 0);
    next_cyc();

    // Directed functional commands
    pat_q = '{1, 1, 1, 1};
    run_cmd("basic", 4, 1'b1);
    pat_q = '{1, 0, 0, 1, 1};
    run_cmd("gapped", 3, 1'b1);
    pat_q.delete();
    run_cmd("clronly", 0, 1'b1);
    pat_q = '{1, 1};
    run_cmd("noclr", 2, 1'b0);

    // Abort mid-LOAD after two beats, with a beat offered in the abort cycle
    op_len = 8'd5; op_clr = 1'b1; op_valid = 1'b1;
    @(negedge clk);
    chk("ab_accept", 32'(op_ready), 1);
    next_cyc();
    op_valid = 1'b0; smp_valid = 1'b1;
    @(negedge clk);
    chk("ab_beat1", 32'(ce_ab), 1);
    next_cyc();
    @(negedge clk);
    chk("ab_beat2", 32'(ce_ab), 1);
    next_cyc();
    abort = 1'b1;
    @(negedge clk);
    chk("ab_no_hs", 32'(ce_ab), 0);
    chk("ab_rst_pipe_same", 32'(rst_pipe), 0);
    next_cyc();
    abort = 1'b0;
    @(negedge clk);
    chk("ab_rst_pipe", 32'(rst_pipe), 1);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_op_ready", 32'(op_ready), 1);
    chk("ab_ce_after", 32'({ce_ab, ce_m, ce_p}), 0);
    n_ce = 0; n_res = 0;
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      @(negedge clk);
      n_ce  += int'(ce_ab) + int'(ce_m) + int'(ce_p);
      n_res += int'(res_valid);
    end
    chk("ab_no_ce", 32'(n_ce), 0);
    chk("ab_no_res", 32'(n_res), 0);
    chk("ab_rst_pipe_once", 32'(rst_pipe), 0);
    smp_valid = 1'b0;
    next_cyc();

    // Abort while idle blocks the command and still pulses rst_pipe
    op_len = 8'd1; op_clr = 1'b0; op_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abidle_op_ready", 32'(op_ready), 0);
    next_cyc();
    abort = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("abidle_rst_pipe", 32'(rst_pipe), 1);
    chk("abidle_busy", 32'(busy), 0);
    next_cyc();

    // Reset during DRAIN
    op_len = 8'd1; op_clr = 1'b1; op_valid = 1'b1;
    @(negedge clk);
    chk("rd_accept", 32'(op_ready), 1);
    next_cyc();
    op_valid = 1'b0; smp_valid = 1'b1;
    @(negedge clk);
    chk("rd_beat", 32'(ce_ab), 1);
    next_cyc();
    smp_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rd_in_drain", 32'(busy), 1);
    chk("rd_rst_pipe_hi", 32'(rst_pipe), 1);
    next_cyc();
    @(negedge clk);
    chk("rd_outputs", 32'({op_ready, smp_ready, ce_ab, ce_m, ce_p, acc_sel, res_valid, busy}), 0);
    chk("rd_rst_pipe", 32'(rst_pipe), 1);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rd_op_ready", 32'(op_ready), 1);
    chk("rd_rst_pipe_lo", 32'(rst_pipe), 0);
    n_res = 0;
    for (int k = 0; k < 5; k++) begin
      next_cyc();
      @(negedge clk);
      n_res += int'(res_valid);
    end
    chk("rd_no_res", 32'(n_res), 0);
    next_cyc();

    // Back-to-back single-beat commands with op_valid held
    op_len = 8'd1; op_clr = 1'b1; op_valid = 1'b1; smp_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (op_valid && op_ready) acc_q.push_back(k);
      if (res_valid) res_q.push_back(k);
      next_cyc();
    end
    op_valid = 1'b0;
    for (int k = 0; k < 8; k++) next_cyc();
    smp_valid = 1'b0;
    chk("b2b_n_acc", 32'(acc_q.size() >= 2), 1);
    chk("b2b_n_res", 32'(res_q.size() >= 1), 1);
    if (acc_q.size() >= 2 && res_q.size() >= 1) begin
      chk("b2b_res_lat", 32'(res_q[0] - acc_q[0]), 32'd4);
      chk("b2b_reaccept", 32'(acc_q[1] - res_q[0]), 32'd1);
    end
    next_cyc();

    // Randomized commands checked against the beat-time model
    for (int r = 0; r < 8; r++) begin
      int len;
      bit clr;
      int ones;
      len  = int'($urandom_range(1, 6));
      clr  = 1'($urandom_range(0, 1));
      ones = 0;
      pat_q.delete();
      while (ones < len) begin
        bit b;
        b = ($urandom_range(0, 9) < 7);
        pat_q.push_back(b);
        if (b) ones++;
      end
      pat_q.push_back(1'($urandom_range(0, 1)));
      pat_q.push_back(1'b1);
      run_cmd($sformatf("rnd%0d", r), len, clr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
